// File: rtl/gpio_apb_regs.sv
// GPIO APB3 register bank.
// Holds the direction, output and interrupt configuration registers that feed
// the GPIO pin controller. It synchronises the raw pin inputs and turns
// INT_STAT writes into one-cycle clear pulses. It also produces the gated CPU
// interrupt. Every APB transfer runs through IDLE -> WAIT -> RESP. Read data is
// captured on entry to RESP, and writes commit on the edge that leaves RESP.
module gpio_apb_regs #(
  parameter int PIN_COUNT  = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  psel,
  input  logic                  penable,
  input  logic                  pwrite,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic [31:0]           pwdata,
  output logic [31:0]           prdata,
  output logic                  pready,
  output logic                  pslverr,
  output logic [PIN_COUNT-1:0]  gpio_dir,
  output logic [PIN_COUNT-1:0]  gpio_out,
  output logic [PIN_COUNT-1:0]  int_enable,
  output logic [PIN_COUNT-1:0]  int_type,
  output logic [PIN_COUNT-1:0]  int_polarity,
  output logic [PIN_COUNT-1:0]  int_clear,
  input  logic [PIN_COUNT-1:0]  gpio_in,
  input  logic [PIN_COUNT-1:0]  int_status,
  output logic                  irq
);

  localparam int WW = ADDR_WIDTH - 2;

  // Word offsets (byte offset >> 2)
  localparam logic [WW-1:0] A_DIR   = WW'(0);
  localparam logic [WW-1:0] A_OUT   = WW'(1);
  localparam logic [WW-1:0] A_SET   = WW'(2);
  localparam logic [WW-1:0] A_CLR   = WW'(3);
  localparam logic [WW-1:0] A_TGL   = WW'(4);
  localparam logic [WW-1:0] A_IN    = WW'(5);
  localparam logic [WW-1:0] A_EN    = WW'(6);
  localparam logic [WW-1:0] A_TYPE  = WW'(7);
  localparam logic [WW-1:0] A_POL   = WW'(8);
  localparam logic [WW-1:0] A_STAT  = WW'(9);
  localparam logic [WW-1:0] A_CTRL  = WW'(10);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_next;

  logic [PIN_COUNT-1:0]   r_dir;
  logic [PIN_COUNT-1:0]   r_out;
  logic [PIN_COUNT-1:0]   r_int_en;
  logic [PIN_COUNT-1:0]   r_int_type;
  logic [PIN_COUNT-1:0]   r_int_pol;
  logic [PIN_COUNT-1:0]   r_int_clear;
  logic                   r_ctrl;
  logic [PIN_COUNT-1:0]   r_in_meta;
  logic [PIN_COUNT-1:0]   r_in_sync;
  logic                   r_irq;
  logic [31:0]            r_prdata;
  logic                   r_pready;
  logic                   r_pslverr;

  logic [WW-1:0]          w_word;
  logic [PIN_COUNT-1:0]   w_wdata;
  logic [31:0]            w_rdata;
  logic                   w_unmapped;
  logic                   w_read_only;
  logic                   w_err;
  logic                   w_commit;
  logic                   w_unused;

  assign w_word   = paddr[ADDR_WIDTH-1:2];
  assign w_wdata  = pwdata[PIN_COUNT-1:0];
  assign w_unused = ^{paddr[1:0], pwdata, penable};

  // Transfer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next-state logic; losing psel in WAIT abandons the transfer
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (psel && penable) w_next = S_WAIT;
        else                 w_next = S_IDLE;
      end
      S_WAIT: begin
        if (psel) w_next = S_RESP;
        else      w_next = S_IDLE;
      end
      S_RESP:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Address decode: read mux plus error classification
  always_comb begin
    w_rdata     = 32'd0;
    w_unmapped  = 1'b0;
    w_read_only = 1'b0;
    case (w_word)
      A_DIR:  w_rdata = 32'(r_dir);
      A_OUT:  w_rdata = 32'(r_out);
      A_SET:  w_rdata = 32'd0;
      A_CLR:  w_rdata = 32'd0;
      A_TGL:  w_rdata = 32'd0;
      A_IN: begin
        w_rdata     = 32'(r_in_sync);
        w_read_only = 1'b1;
      end
      A_EN:   w_rdata = 32'(r_int_en);
      A_TYPE: w_rdata = 32'(r_int_type);
      A_POL:  w_rdata = 32'(r_int_pol);
      A_STAT: w_rdata = 32'(int_status);
      A_CTRL: w_rdata = {31'd0, r_ctrl};
      default: w_unmapped = 1'b1;
    endcase
  end

  assign w_err    = w_unmapped | (pwrite & w_read_only);
  assign w_commit = (r_state == S_RESP) & pwrite & ~w_err;

  // Response registers: loaded on entry to RESP, cleared otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= 32'd0;
    end else if ((r_state == S_WAIT) && (w_next == S_RESP)) begin
      r_pready  <= 1'b1;
      r_pslverr <= w_err;
      r_prdata  <= pwrite ? 32'd0 : w_rdata;
    end else begin
      r_pready  <= 1'b0;
      r_pslverr <= 1'b0;
      r_prdata  <= 32'd0;
    end
  end

  // Configuration registers; SET/CLR/TGL act on the committed OUT value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dir      <= '0;
      r_out      <= '0;
      r_int_en   <= '0;
      r_int_type <= '0;
      r_int_pol  <= '0;
      r_ctrl     <= 1'b0;
    end else if (w_commit) begin
      case (w_word)
        A_DIR:  r_dir      <= w_wdata;
        A_OUT:  r_out      <= w_wdata;
        A_SET:  r_out      <= r_out | w_wdata;
        A_CLR:  r_out      <= r_out & ~w_wdata;
        A_TGL:  r_out      <= r_out ^ w_wdata;
        A_EN:   r_int_en   <= w_wdata;
        A_TYPE: r_int_type <= w_wdata;
        A_POL:  r_int_pol  <= w_wdata;
        A_CTRL: r_ctrl     <= pwdata[0];
        default: r_ctrl    <= r_ctrl;
      endcase
    end else begin
      r_ctrl <= r_ctrl;
    end
  end

  // Interrupt clear pulse: one cycle wide, following an INT_STAT write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_clear <= '0;
    end else if (w_commit && (w_word == A_STAT)) begin
      r_int_clear <= w_wdata;
    end else begin
      r_int_clear <= '0;
    end
  end

  // Two-flop synchroniser for the raw pin inputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_meta <= '0;
      r_in_sync <= '0;
    end else begin
      r_in_meta <= gpio_in;
      r_in_sync <= r_in_meta;
    end
  end

  // CPU interrupt: any pending status, gated by the global enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else begin
      r_irq <= r_ctrl & (|int_status);
    end
  end

  assign prdata       = r_prdata;
  assign pready       = r_pready;
  assign pslverr      = r_pslverr;
  assign gpio_dir     = r_dir;
  assign gpio_out     = r_out;
  assign int_enable   = r_int_en;
  assign int_type     = r_int_type;
  assign int_polarity = r_int_pol;
  assign int_clear    = r_int_clear;
  assign irq          = r_irq;

endmodule

// File: tb/tb_gpio_apb_regs.sv
// Self-checking bench for gpio_apb_regs: scoreboarded APB reads/writes plus
// direct checks on the controller-facing outputs.
module tb_gpio_apb_regs;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        psel = 1'b0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [7:0]  paddr = 8'd0;
  logic [31:0] pwdata = 32'd0;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;
  logic [31:0] gpio_dir, gpio_out, int_enable, int_type, int_polarity, int_clear;
  logic [31:0] gpio_in = 32'd0;
  logic [31:0] int_status = 32'd0;
  logic        irq;

  typedef struct packed {
    logic        chk;
    logic        err;
    logic [31:0] data;
  } exp_t;

  exp_t        exp_q[$];
  logic [32:0] got_q[$];
  int          checks = 0;
  int          errors = 0;
  int          last_wait = 0;

  gpio_apb_regs #(.PIN_COUNT(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .gpio_dir(gpio_dir), .gpio_out(gpio_out),
    .int_enable(int_enable), .int_type(int_type), .int_polarity(int_polarity),
    .int_clear(int_clear), .gpio_in(gpio_in), .int_status(int_status), .irq(irq)
  );

  always #5 clk = ~clk;

  // One APB transfer; the response is pushed to got_q. in_chg changes
  // gpio_in at the start of the first access cycle.
  task automatic apb(input logic wr, input logic [7:0] addr, input logic [31:0] wdata,
                     input logic in_chg, input logic [31:0] in_val);
    int   waits;
    logic done;
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = addr; pwdata = wdata;
    @(posedge clk); #1;
    penable = 1'b1;
    if (in_chg) gpio_in = in_val;
    waits = 0;
    done  = 1'b0;
    for (int i = 0; i < 8 && !done; i++) begin
      @(posedge clk); #1;
      if (pready === 1'b1) done = 1'b1;
      else                 waits++;
    end
    last_wait = waits;
    if (done) begin
      got_q.push_back({pslverr, prdata});
    end else begin
      checks++;
      errors++;
      $display("FAIL pready_timeout addr=%h got no pready, need pready within 8 cycles", addr);
      got_q.push_back(33'h1_FFFF_FFFF);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp_data, input logic exp_err);
    exp_t e;
    e.chk = 1'b1; e.err = exp_err; e.data = exp_data;
    exp_q.push_back(e);
    apb(1'b0, addr, 32'd0, 1'b0, 32'd0);
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data, input logic exp_err);
    exp_t e;
    e.chk = 1'b0; e.err = exp_err; e.data = 32'd0;
    exp_q.push_back(e);
    apb(1'b1, addr, data, 1'b0, 32'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    exp_t e;
    logic [32:0] g;
    do_reset();
    checks++;
    if ({gpio_dir, gpio_out, int_enable, int_type, int_polarity, int_clear} !== 192'd0) begin
      errors++;
      $display("FAIL reset_outputs got dir=%h out=%h en=%h ty=%h pol=%h clr=%h need all 0",
               gpio_dir, gpio_out, int_enable, int_type, int_polarity, int_clear);
    end
    checks++;
    if ({irq, pready, pslverr, prdata} !== 35'd0) begin
      errors++;
      $display("FAIL reset_apb got irq=%b pready=%b pslverr=%b prdata=%h need 0", irq, pready, pslverr, prdata);
    end
    rd(8'h00, 32'd0, 1'b0);
    checks++;
    if (last_wait !== 1) begin
      errors++;
      $display("FAIL reset_wait_states got %0d need 1", last_wait);
    end
    for (int a = 1; a < 11; a++) rd(8'(a * 4), 32'd0, 1'b0);
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g[32] !== e.err || (e.chk && g[31:0] !== e.data)) begin
        errors++;
        $display("FAIL reset_read got err=%b data=%h need err=%b data=%h", g[32], g[31:0], e.err, e.data);
      end
    end
  endtask

  task automatic test_out_ops();
    exp_t e;
    logic [32:0] g;
    logic [31:0] exp_out [5];
    logic [7:0]  addrs [5];
    logic [31:0] vals [5];
    addrs = '{8'h04, 8'h08, 8'h0C, 8'h10, 8'h07};
    vals  = '{32'h0000_A5A5, 32'h0000_000F, 32'h0000_0005, 32'h0000_0300, 32'h0000_0000};
    exp_out = '{32'h0000_A5A5, 32'h0000_A5AF, 32'h0000_A5AA, 32'h0000_A6AA, 32'h0000_A6AA};
    wr(8'h00, 32'hFFFF_0000, 1'b0);
    checks++;
    if (gpio_dir !== 32'hFFFF_0000) begin
      errors++;
      $display("FAIL dir_out got %h need %h", gpio_dir, 32'hFFFF_0000);
    end
    for (int i = 0; i < 4; i++) begin
      wr(addrs[i], vals[i], 1'b0);
      checks++;
      if (gpio_out !== exp_out[i]) begin
        errors++;
        $display("FAIL out_op%0d got %h need %h", i, gpio_out, exp_out[i]);
      end
    end
    rd(8'h00, 32'hFFFF_0000, 1'b0);
    rd(addrs[4], exp_out[4], 1'b0);
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g[32] !== e.err || (e.chk && g[31:0] !== e.data)) begin
        errors++;
        $display("FAIL out_ops_xfer got err=%b data=%h need err=%b data=%h", g[32], g[31:0], e.err, e.data);
      end
    end
  endtask

  task automatic test_in_sync();
    exp_t e;
    logic [32:0] g;
    e.chk = 1'b1; e.err = 1'b0; e.data = 32'd0;
    exp_q.push_back(e);
    apb(1'b0, 8'h14, 32'd0, 1'b1, 32'h1234_5678);
    rd(8'h14, 32'h1234_5678, 1'b0);
    gpio_in = 32'hCAFE_F00D;
    rd(8'h14, 32'hCAFE_F00D, 1'b0);
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g[32] !== e.err || (e.chk && g[31:0] !== e.data)) begin
        errors++;
        $display("FAIL in_sync got err=%b data=%h need err=%b data=%h", g[32], g[31:0], e.err, e.data);
      end
    end
  endtask

  task automatic test_irq();
    exp_t e;
    logic [32:0] g;
    int_status = 32'h0000_0081;
    wr(8'h28, 32'hFFFF_FFFF, 1'b0);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_latency got %b need 0", irq); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_set got %b need 1", irq); end
    rd(8'h24, 32'h0000_0081, 1'b0);
    rd(8'h28, 32'h0000_0001, 1'b0);
    wr(8'h24, 32'h0000_0080, 1'b0);
    checks++;
    if (int_clear !== 32'h0000_0080) begin errors++; $display("FAIL int_clear_pulse got %h need %h", int_clear, 32'h80); end
    int_status = 32'd0;
    @(posedge clk); #1;
    checks++;
    if (int_clear !== 32'd0) begin errors++; $display("FAIL int_clear_width got %h need 0", int_clear); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_status_drop got %b need 0", irq); end
    int_status = 32'h0000_0081;
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_status_rise got %b need 1", irq); end
    wr(8'h28, 32'd0, 1'b0);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_ctrl_latency got %b need 1", irq); end
    @(posedge clk); #1;
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_ctrl_off got %b need 0", irq); end
    wr(8'h18, 32'h0000_00FF, 1'b0);
    wr(8'h1C, 32'h0F0F_0000, 1'b0);
    wr(8'h20, 32'h8000_0001, 1'b0);
    checks++;
    if ({int_enable, int_type, int_polarity} !== {32'h0000_00FF, 32'h0F0F_0000, 32'h8000_0001}) begin
      errors++;
      $display("FAIL int_cfg got en=%h ty=%h pol=%h need 000000ff 0f0f0000 80000001", int_enable, int_type, int_polarity);
    end
    rd(8'h1C, 32'h0F0F_0000, 1'b0);
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g[32] !== e.err || (e.chk && g[31:0] !== e.data)) begin
        errors++;
        $display("FAIL irq_xfer got err=%b data=%h need err=%b data=%h", g[32], g[31:0], e.err, e.data);
      end
    end
  endtask

  task automatic test_errors();
    exp_t e;
    logic [32:0] g;
    wr(8'h3C, 32'hFFFF_FFFF, 1'b1);
    wr(8'h14, 32'hFFFF_FFFF, 1'b1);
    checks++;
    if ({gpio_dir, gpio_out} !== {32'hFFFF_0000, 32'h0000_A6AA}) begin
      errors++;
      $display("FAIL err_no_effect got dir=%h out=%h need ffff0000 0000a6aa", gpio_dir, gpio_out);
    end
    rd(8'h3C, 32'd0, 1'b1);
    rd(8'h14, 32'hCAFE_F00D, 1'b0);
    rd(8'h08, 32'd0, 1'b0);
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g[32] !== e.err || (e.chk && g[31:0] !== e.data)) begin
        errors++;
        $display("FAIL err_xfer got err=%b data=%h need err=%b data=%h", g[32], g[31:0], e.err, e.data);
      end
    end
  endtask

  task automatic test_abort();
    exp_t e;
    logic [32:0] g;
    // psel lost in WAIT: nothing commits, no pready
    wr(8'h04, 32'h0000_5555, 1'b0);
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'h0000_1234;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++;
      if (pready !== 1'b0 || gpio_out !== 32'h0000_5555) begin
        errors++;
        $display("FAIL psel_drop got pready=%b out=%h need 0 00005555", pready, gpio_out);
      end
    end
    pwrite = 1'b0;
    rd(8'h04, 32'h0000_5555, 1'b0);
    // reset during WAIT of an OUT write
    do_reset();
    @(posedge clk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h04; pwdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (pready !== 1'b0 || gpio_out !== 32'd0) begin
      errors++;
      $display("FAIL abort_in_reset got pready=%b out=%h need 0 0", pready, gpio_out);
    end
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pready !== 1'b0 || gpio_out !== 32'd0) begin
      errors++;
      $display("FAIL abort_after got pready=%b out=%h need 0 0", pready, gpio_out);
    end
    rd(8'h04, 32'd0, 1'b0);
    checks++;
    if (last_wait !== 1) begin
      errors++;
      $display("FAIL abort_idle_timing got %0d wait cycles need 1", last_wait);
    end
    while (exp_q.size() != 0 && got_q.size() != 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front(); checks++;
      if (g[32] !== e.err || (e.chk && g[31:0] !== e.data)) begin
        errors++;
        $display("FAIL abort_xfer got err=%b data=%h need err=%b data=%h", g[32], g[31:0], e.err, e.data);
      end
    end
  endtask

  // Test sequence
  initial begin
    test_reset();
    test_out_ops();
    test_in_sync();
    test_irq();
    test_errors();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time bound
  initial begin
    #200000;
    $display("FAIL watchdog got no completion need finish before 200000");
    $fatal(1);
  end

endmodule
